// File: rtl/riscv_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_core_mem_arbiter
//
// Shares one memory port between the core's instruction-fetch (imem) and data
// (dmem) requesters. One request is granted per cycle. Data requests win by
// default. After STARVE_LIM consecutive lost arbitrations, fetch gets priority
// for one grant. Each granted request records its owner in an in-order tag
// FIFO. Each in-order memory response is steered back to the owner at the
// FIFO head.
//
// Parameters
//   DEPTH       maximum outstanding requests (power of two, >= 2)
//   STARVE_LIM  consecutive lost imem arbitrations before imem gets priority
//
// Ports
//   clk, reset                       clock, asynchronous active-high reset
//   imemreq_*  / imemresp_*          fetch request (val/rdy/addr), response
//   dmemreq_*  / dmemresp_*          data request (val/rdy/rw/len/addr/data),
//                                    response (includes store acks)
//   memreq_*   / memresp_*           shared memory request and response
//   outstanding                      current tag FIFO occupancy
//   err_spurious                     sticky: response seen with nothing pending
// -----------------------------------------------------------------------------
module riscv_core_mem_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   imemreq_val,
    output logic                   imemreq_rdy,
    input  logic [31:0]            imemreq_msg_addr,
    output logic                   imemresp_val,
    output logic [31:0]            imemresp_msg_data,

    input  logic                   dmemreq_val,
    output logic                   dmemreq_rdy,
    input  logic                   dmemreq_msg_rw,
    input  logic [1:0]             dmemreq_msg_len,
    input  logic [31:0]            dmemreq_msg_addr,
    input  logic [31:0]            dmemreq_msg_data,
    output logic                   dmemresp_val,
    output logic [31:0]            dmemresp_msg_data,

    output logic                   memreq_val,
    input  logic                   memreq_rdy,
    output logic                   memreq_msg_rw,
    output logic [1:0]             memreq_msg_len,
    output logic [31:0]            memreq_msg_addr,
    output logic [31:0]            memreq_msg_data,
    input  logic                   memresp_val,
    input  logic [31:0]            memresp_msg_data,

    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_spurious
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    // Tag values stored per outstanding request.
    localparam logic TAG_IMEM = 1'b0;
    localparam logic TAG_DMEM = 1'b1;

    logic [DEPTH-1:0] tag_q,        tag_d;
    logic [PW-1:0]    head_q,       head_d;
    logic [PW-1:0]    tail_q,       tail_d;
    logic [CW-1:0]    count_q,      count_d;
    logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
    logic             err_spurious_q, err_spurious_d;

    logic full;
    logic imem_pri;
    logic grant_i;
    logic grant_d;
    logic can_issue;
    logic fire;
    logic push;
    logic pop;
    logic head_tag;

    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        imem_pri  = (starve_cnt_q == SW'(STARVE_LIM));

        // dmem wins whenever it is valid, unless fetch has been starved and is
        // also asking. A winner's rdy never looks at the loser's val.
        grant_d   = dmemreq_val & ~(imemreq_val & imem_pri);
        grant_i   = imemreq_val & ~grant_d;

        // Nothing is handshaken while reset is held: the FIFO would forget it.
        can_issue = ~full & ~reset;

        memreq_val  = (imemreq_val | dmemreq_val) & can_issue;
        imemreq_rdy = grant_i & memreq_rdy & can_issue;
        dmemreq_rdy = grant_d & memreq_rdy & can_issue;

        if (grant_d) begin
            memreq_msg_rw   = dmemreq_msg_rw;
            memreq_msg_len  = dmemreq_msg_len;
            memreq_msg_addr = dmemreq_msg_addr;
            memreq_msg_data = dmemreq_msg_data;
        end else begin
            memreq_msg_rw   = 1'b0;
            memreq_msg_len  = 2'd0;
            memreq_msg_addr = imemreq_msg_addr;
            memreq_msg_data = 32'd0;
        end

        fire = memreq_val & memreq_rdy;
        // full already blocks memreq_val, so a pop in the same cycle never
        // lets a push through.
        push = fire;
        pop  = memresp_val & (count_q != '0);

        head_tag          = tag_q[head_q];
        imemresp_val      = pop & (head_tag == TAG_IMEM);
        dmemresp_val      = pop & (head_tag == TAG_DMEM);
        imemresp_msg_data = memresp_msg_data;
        dmemresp_msg_data = memresp_msg_data;

        tag_d = tag_q;
        if (push) begin
            tag_d[tail_q] = grant_d ? TAG_DMEM : TAG_IMEM;
        end
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        head_d  = pop  ? head_q + PW'(1) : head_q;
        count_d = count_q + CW'(push) - CW'(pop);

        // Starvation counts only real losses: dmem actually fired while fetch
        // was waiting. A stalled memory port leaves the count alone.
        starve_cnt_d = starve_cnt_q;
        if (fire && grant_i) begin
            starve_cnt_d = '0;
        end else if (fire && grant_d && imemreq_val && !imem_pri) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        err_spurious_d = err_spurious_q | (memresp_val & (count_q == '0));

        outstanding  = count_q;
        err_spurious = err_spurious_q;
    end

    // NOTE: tag storage is not reset; an entry is only read while count is
    // nonzero, i.e. after it has been written, so stale contents are harmless.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            starve_cnt_q   <= '0;
            err_spurious_q <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            starve_cnt_q   <= starve_cnt_d;
            err_spurious_q <= err_spurious_d;
        end
    end

endmodule
